spi_adc_multi: RTL and testbench

SPI_ADC_MULTI -- requirements
Module: spi_adc_multi

---
 rtl/spi_adc_pkg.sv | 19 +
 rtl/spi_adc_multi_if.sv | 28 ++
 rtl/spi_adc_shreg.sv | 30 +++
 rtl/spi_adc_multi.sv | 143 ++++++++++++++
 tb/tb_spi_adc_multi.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_adc_pkg.sv
// Shared types and default constants for the multi-channel SPI ADC reader.
// FSM state encoding lives here so the top and any future blocks agree.
package spi_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    WAIT_BUSY,
    SHIFT,
    DONE
  } state_t;

  localparam int DEF_N_CH       = 2;
  localparam int DEF_DATA_W     = 12;
  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_TMO_CYC    = 1024;

endpackage

// File: rtl/spi_adc_multi_if.sv
// ADC-side bus: shared SCLK/CONVST, shared BUSY, one SDAT line per channel.
// master = reader (this design), slave = the ADC bank.
interface spi_adc_multi_if
  import spi_adc_pkg::*;
#(
  parameter int N_CH = DEF_N_CH
);

  logic            SCLK;
  logic            CONVST;
  logic            BUSY;
  logic [N_CH-1:0] SDAT;

  modport master (
    output SCLK,
    output CONVST,
    input  BUSY,
    input  SDAT
  );

  modport slave (
    input  SCLK,
    input  CONVST,
    output BUSY,
    output SDAT
  );

endinterface

// File: rtl/spi_adc_shreg.sv
// Per-channel MSB-first frame shift register.
// Only the last DATA_W bits shifted in are presented as the result.
module spi_adc_shreg
  import spi_adc_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              din,
  output logic [DATA_W-1:0] dat
);

  logic [FRAME_BITS-1:0] sr;
  logic                  unused_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (en) begin
      sr <= {sr[FRAME_BITS-2:0], din};
    end
  end

  assign dat        = sr[DATA_W-1:0];
  assign unused_msb = sr[FRAME_BITS-1];

endmodule

// File: rtl/spi_adc_multi.sv
// Multi-channel SPI ADC reader: CONVST pulse, wait BUSY, shared-SCLK frame.
// Define SPI_ADC_TMO_EN to enable the BUSY timeout and sticky err_tmo.
module spi_adc_multi
  import spi_adc_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int TMO_CYC    = DEF_TMO_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   st,
  input  logic                   cont,
  input  logic [15:0]            period,
  spi_adc_multi_if.master        bus,
  output logic [N_CH*DATA_W-1:0] adc_dat,
  output logic                   ok_adc,
  output logic                   active,
  output logic                   err_tmo
);

  localparam int CW = $clog2(TMO_CYC + 2*CLK_DIV + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);

  state_t                 state;
  state_t                 nxt;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bcnt;
  logic [15:0]            pcnt;
  logic                   sclk;
  logic                   b1;
  logic                   b2;
  logic                   b3;
  logic                   busy_fall;
  logic                   half_end;
  logic                   shift_en;
  logic [N_CH*DATA_W-1:0] res;
`ifdef SPI_ADC_TMO_EN
  logic                   tmo_hit;
`endif

  assign busy_fall = b3 & ~b2;
  assign half_end  = (cnt == CW'(CLK_DIV - 1));

  always_comb begin
    nxt      = state;
    shift_en = 1'b0;
`ifdef SPI_ADC_TMO_EN
    tmo_hit  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        // pcnt<=1 here makes CONV entries land exactly period apart
        if (st || (cont && pcnt <= 16'd1)) nxt = CONV;
      end
      CONV: begin
        if (cnt == CW'(2*CLK_DIV - 1)) nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy_fall) nxt = SHIFT;
`ifdef SPI_ADC_TMO_EN
        else if (cnt == CW'(TMO_CYC - 1)) begin
          nxt     = IDLE;
          tmo_hit = 1'b1;
        end
`endif
      end
      SHIFT: begin
        if (half_end) begin
          if (!sclk) shift_en = 1'b1;
          else if (bcnt == BW'(FRAME_BITS - 1)) nxt = DONE;
        end
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      bcnt  <= '0;
      pcnt  <= '0;
      sclk  <= 1'b0;
      b1    <= 1'b0;
      b2    <= 1'b0;
      b3    <= 1'b0;
    end else begin
      state <= nxt;
      b1    <= bus.BUSY;
      b2    <= b1;
      b3    <= b2;
      if (nxt != state || (state == SHIFT && half_end)) cnt <= '0;
      else if (state != IDLE) cnt <= cnt + CW'(1);
      sclk <= (state == SHIFT && nxt == SHIFT) ? (sclk ^ half_end) : 1'b0;
      if (state != SHIFT) bcnt <= '0;
      else if (half_end && sclk) bcnt <= bcnt + BW'(1);
      if (state == IDLE && nxt == CONV) pcnt <= period;
      else if (pcnt != 16'd0) pcnt <= pcnt - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_dat <= '0;
      ok_adc  <= 1'b0;
    end else begin
      ok_adc <= (state == DONE);
      if (state == DONE) adc_dat <= res;
    end
  end

`ifdef SPI_ADC_TMO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_tmo <= 1'b0;
    else if (tmo_hit) err_tmo <= 1'b1;
    else if (st) err_tmo <= 1'b0;
  end
`else
  assign err_tmo = 1'b0;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    spi_adc_shreg #(
      .FRAME_BITS(FRAME_BITS),
      .DATA_W    (DATA_W)
    ) u_sr (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (shift_en),
      .din  (bus.SDAT[c]),
      .dat  (res[c*DATA_W +: DATA_W])
    );
  end

  assign bus.SCLK   = sclk;
  assign bus.CONVST = (state != CONV);
  assign active     = (state != IDLE);

endmodule

// File: tb/tb_spi_adc_multi.sv
// Directed bench for spi_adc_multi with a two-channel behavioural ADC model.
// Each scenario task does its own inline comparisons.
module tb_spi_adc_multi;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        st     = 1'b0;
  logic        cont   = 1'b0;
  logic [15:0] period = 16'd0;
  logic [23:0] adc_dat;
  logic        ok_adc;
  logic        active;
  logic        err_tmo;

  spi_adc_multi_if #(.N_CH(2)) bus();

  spi_adc_multi #(
    .N_CH      (2),
    .DATA_W    (12),
    .FRAME_BITS(16),
    .CLK_DIV   (4),
    .TMO_CYC   (1024)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .st     (st),
    .cont   (cont),
    .period (period),
    .bus    (bus.master),
    .adc_dat(adc_dat),
    .ok_adc (ok_adc),
    .active (active),
    .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int   cyc       = 0;
  int   ok_cnt    = 0;
  int   conv_low  = 0;
  int   sclk_rise = 0;
  int   sclk_hi   = 0;
  int   rise_cyc  = 0;
  int   err_cyc   = -1;
  int   falls[$];
  int   rises[$];
  logic pconv = 1'b1;
  logic psclk = 1'b0;
  logic perr  = 1'b0;

  logic [15:0] w0 = 16'h0;
  logic [15:0] w1 = 16'h0;
  int          busy_dly  = 40;
  logic        hold_busy = 1'b0;
  int          bit_i     = -1;

  assign bus.SDAT = (bit_i >= 0) ? {w1[bit_i[3:0]], w0[bit_i[3:0]]} : 2'b00;

  // ADC model: BUSY rises on CONVST fall, data shifts out on SCLK fall
  initial begin
    bit i_held;
    int n;
    bus.BUSY = 1'b0;
    forever begin
      @(negedge bus.CONVST);
      bus.BUSY = 1'b1;
      n = 0;
      i_held = 1'b0;
      while (n < busy_dly || hold_busy) begin
        @(negedge clk);
        n++;
        if (hold_busy) i_held = 1'b1;
      end
      if (!i_held) bit_i = 15;
      bus.BUSY = 1'b0;
      while (bit_i >= 0) begin
        @(negedge bus.SCLK or negedge rst_n);
        if (!rst_n) break;
        bit_i = bit_i - 1;
      end
      bit_i = -1;
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (ok_adc) ok_cnt++;
    if (!bus.CONVST) conv_low++;
    if (pconv && !bus.CONVST) falls.push_back(cyc);
    if (!pconv && bus.CONVST) rise_cyc = cyc;
    if (bus.SCLK) sclk_hi++;
    if (bus.SCLK && !psclk) begin
      sclk_rise++;
      rises.push_back(cyc);
    end
    if (err_tmo && !perr) err_cyc = cyc;
    pconv = bus.CONVST;
    psclk = bus.SCLK;
    perr  = err_tmo;
  end

  task automatic pulse_st;
    @(negedge clk) st = 1'b1;
    @(negedge clk) st = 1'b0;
  endtask

  task automatic clr_mon;
    ok_cnt    = 0;
    conv_low  = 0;
    sclk_rise = 0;
    sclk_hi   = 0;
    err_cyc   = -1;
    falls.delete();
    rises.delete();
  endtask

  task automatic wait_idle(input int budget, output bit done);
    done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!active) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.SCLK !== 1'b0) begin
      failures++;
      $display("FAIL rst_sclk got=%b exp=0", bus.SCLK);
    end
    checks++;
    if (bus.CONVST !== 1'b1) begin
      failures++;
      $display("FAIL rst_convst got=%b exp=1", bus.CONVST);
    end
    checks++;
    if (adc_dat !== 24'h0) begin
      failures++;
      $display("FAIL rst_dat got=%h exp=0", adc_dat);
    end
    checks++;
    if (ok_adc !== 1'b0) begin
      failures++;
      $display("FAIL rst_ok got=%b exp=0", ok_adc);
    end
    checks++;
    if (active !== 1'b0) begin
      failures++;
      $display("FAIL rst_active got=%b exp=0", active);
    end
    checks++;
    if (err_tmo !== 1'b0) begin
      failures++;
      $display("FAIL rst_err got=%b exp=0", err_tmo);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    bit done;
    int bad;
    w0 = 16'h0ABC;
    w1 = 16'h0123;
    @(negedge clk) clr_mon();
    pulse_st();
    checks++;
    if (active !== 1'b1) begin
      failures++;
      $display("FAIL single_active got=%b exp=1", active);
    end
    wait_idle(2000, done);
    repeat (3) @(negedge clk);
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL single_timeout got=busy exp=idle");
    end
    checks++;
    if (adc_dat !== 24'h123ABC) begin
      failures++;
      $display("FAIL single_dat got=%h exp=123abc", adc_dat);
    end
    checks++;
    if (ok_cnt != 1) begin
      failures++;
      $display("FAIL single_ok got=%0d exp=1", ok_cnt);
    end
    checks++;
    if (conv_low != 8) begin
      failures++;
      $display("FAIL convst_low got=%0d exp=8", conv_low);
    end
    checks++;
    if (sclk_rise != 16) begin
      failures++;
      $display("FAIL sclk_pulses got=%0d exp=16", sclk_rise);
    end
    bad = 0;
    for (int i = 1; i < rises.size(); i++)
      if (rises[i] - rises[i-1] != 8) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL sclk_period got=%0d_bad exp=0_bad", bad);
    end
    checks++;
    if (sclk_hi != 64) begin
      failures++;
      $display("FAIL sclk_high got=%0d exp=64", sclk_hi);
    end
  endtask

  task automatic test_discard_hold;
    bit done;
    w0 = 16'hF555;
    w1 = 16'h8FFF;
    @(negedge clk) clr_mon();
    pulse_st();
    wait_idle(2000, done);
    repeat (3) @(negedge clk);
    checks++;
    if (!done || adc_dat !== 24'hFFF555) begin
      failures++;
      $display("FAIL discard_dat got=%h exp=fff555", adc_dat);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (adc_dat !== 24'hFFF555 || ok_cnt != 1) begin
      failures++;
      $display("FAIL hold_dat got=%h/%0d exp=fff555/1", adc_dat, ok_cnt);
    end
  endtask

  task automatic test_cont;
    int n;
    w0 = 16'h0246;
    w1 = 16'h0135;
    @(negedge clk) clr_mon();
    period = 16'd500;
    cont   = 1'b1;
    n = 0;
    while (falls.size() < 4 && n < 2600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (falls.size() < 4) begin
      failures++;
      $display("FAIL cont_start got=%0d exp=4", falls.size());
    end
    repeat (80) @(negedge clk);
    cont = 1'b0;
    repeat (1200) @(negedge clk);
    checks++;
    if (falls.size() != 4) begin
      failures++;
      $display("FAIL cont_falls got=%0d exp=4", falls.size());
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (falls.size() < 4 || falls[i] - falls[i-1] != 500) begin
        failures++;
        $display("FAIL cont_gap%0d got=%0d exp=500", i,
                 (falls.size() >= 4) ? falls[i] - falls[i-1] : -1);
      end
    end
    checks++;
    if (ok_cnt != 4) begin
      failures++;
      $display("FAIL cont_ok got=%0d exp=4", ok_cnt);
    end
    checks++;
    if (active !== 1'b0 || adc_dat !== 24'h135246) begin
      failures++;
      $display("FAIL cont_end got=%b/%h exp=0/135246", active, adc_dat);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    w0 = 16'h0ABC;
    w1 = 16'h0123;
    @(negedge clk) clr_mon();
    pulse_st();
    n = 0;
    while (sclk_rise < 8 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sclk_rise < 8 || bus.SCLK !== 1'b1) begin
      failures++;
      $display("FAIL rmid_reach got=%0d/%b exp=8/1", sclk_rise, bus.SCLK);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.SCLK !== 1'b0 || bus.CONVST !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pins got=%b%b exp=01", bus.SCLK, bus.CONVST);
    end
    checks++;
    if (adc_dat !== 24'h0) begin
      failures++;
      $display("FAIL rmid_dat got=%h exp=0", adc_dat);
    end
    checks++;
    if (active !== 1'b0 || ok_adc !== 1'b0) begin
      failures++;
      $display("FAIL rmid_state got=%b%b exp=00", active, ok_adc);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (ok_cnt != 0 || adc_dat !== 24'h0) begin
      failures++;
      $display("FAIL rmid_ok got=%0d/%h exp=0/0", ok_cnt, adc_dat);
    end
  endtask

  task automatic test_st_ignored;
    int  n;
    bit  done;
    w0 = 16'h0321;
    w1 = 16'h0FED;
    @(negedge clk) clr_mon();
    pulse_st();
    n = 0;
    while (sclk_rise < 4 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    pulse_st();
    wait_idle(2000, done);
    repeat (300) @(negedge clk);
    checks++;
    if (!done || ok_cnt != 1) begin
      failures++;
      $display("FAIL stig_ok got=%0d exp=1", ok_cnt);
    end
    checks++;
    if (falls.size() != 1) begin
      failures++;
      $display("FAIL stig_conv got=%0d exp=1", falls.size());
    end
    checks++;
    if (adc_dat !== 24'hFED321) begin
      failures++;
      $display("FAIL stig_dat got=%h exp=fed321", adc_dat);
    end
  endtask

  task automatic test_timeout;
    bit done;
`ifdef SPI_ADC_TMO_EN
    int n;
    w0 = 16'h0777;
    w1 = 16'h0888;
    hold_busy = 1'b1;
    @(negedge clk) clr_mon();
    pulse_st();
    n = 0;
    while (!err_tmo && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (err_cyc - rise_cyc != 1024) begin
      failures++;
      $display("FAIL tmo_time got=%0d exp=1024", err_cyc - rise_cyc);
    end
    checks++;
    if (ok_cnt != 0 || active !== 1'b0 || err_tmo !== 1'b1) begin
      failures++;
      $display("FAIL tmo_state got=%0d/%b/%b exp=0/0/1", ok_cnt, active, err_tmo);
    end
    hold_busy = 1'b0;
    repeat (5) @(negedge clk);
    pulse_st();
    checks++;
    if (err_tmo !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear got=%b exp=0", err_tmo);
    end
    wait_idle(2000, done);
    repeat (3) @(negedge clk);
    checks++;
    if (!done || ok_cnt != 1 || adc_dat !== 24'h888777) begin
      failures++;
      $display("FAIL tmo_after got=%0d/%h exp=1/888777", ok_cnt, adc_dat);
    end
`else
    w0 = 16'h0777;
    w1 = 16'h0888;
    busy_dly = 1500;
    @(negedge clk) clr_mon();
    pulse_st();
    wait_idle(4000, done);
    repeat (3) @(negedge clk);
    busy_dly = 40;
    checks++;
    if (err_tmo !== 1'b0 || err_cyc != -1) begin
      failures++;
      $display("FAIL notmo_err got=%b/%0d exp=0/-1", err_tmo, err_cyc);
    end
    checks++;
    if (!done || ok_cnt != 1 || adc_dat !== 24'h888777) begin
      failures++;
      $display("FAIL notmo_wait got=%0d/%h exp=1/888777", ok_cnt, adc_dat);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_discard_hold();
    test_cont();
    test_reset_mid();
    test_st_ignored();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
